// File: rtl/ascon_round_counter.sv
// Round sequencer for the Ascon permutation: loads a round count and steps it
// down by UNROLL rounds per enabled cycle, with start/busy/done/abort handshake.
//
// state | meaning
// IDLE  | waiting for start_i; remaining is 0 and no round is executed
// RUN   | one step of up to UNROLL rounds per cycle where en_i is high
module ascon_round_counter #(
    parameter int  WIDTH      = 4,
    parameter int  MAX_ROUNDS = 12,
    parameter int  UNROLL     = 1,
    localparam int SW         = $clog2(UNROLL + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en_i,
    input  logic             start_i,
    input  logic [WIDTH-1:0] rounds_i,
    input  logic             abort_i,
    output logic             busy_o,
    output logic             last_o,
    output logic             done_o,
    output logic [WIDTH-1:0] remaining_o,
    output logic [WIDTH-1:0] rnd_idx_o,
    output logic [SW-1:0]    step_o
);

    if ((2 ** WIDTH) <= MAX_ROUNDS || UNROLL < 1 || UNROLL > MAX_ROUNDS) begin : g_param_check
        $fatal(1, "ascon_round_counter: illegal WIDTH/MAX_ROUNDS/UNROLL combination");
    end

    localparam logic [WIDTH-1:0] MAX_W    = WIDTH'(MAX_ROUNDS);
    localparam logic [WIDTH-1:0] UNROLL_W = WIDTH'(UNROLL);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] remaining_q, remaining_d;
    logic             done_q, done_d;

    logic             busy;
    logic             last;
    logic [WIDTH-1:0] step_w;
    logic [WIDTH-1:0] load_val;

    always_comb begin
        busy     = (state_q == ST_RUN);
        step_w   = '0;
        last     = 1'b0;
        if (busy) begin
            step_w = (remaining_q < UNROLL_W) ? remaining_q : UNROLL_W;
            last   = (remaining_q <= UNROLL_W);
        end
        load_val = (rounds_i > MAX_W) ? MAX_W : rounds_i;
    end

    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        done_d      = 1'b0;
        if (abort_i) begin
            state_d     = ST_IDLE;
            remaining_d = '0;
        end else if (state_q == ST_IDLE) begin
            if (start_i) begin
                remaining_d = load_val;
                // A zero-length request completes immediately without entering RUN.
                if (load_val == '0) begin
                    done_d = 1'b1;
                end else begin
                    state_d = ST_RUN;
                end
            end
        end else if (en_i) begin
            remaining_d = remaining_q - step_w;
            if (last) begin
                state_d = ST_IDLE;
                done_d  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            remaining_q <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            done_q      <= done_d;
        end
    end

    assign busy_o      = busy;
    assign last_o      = last;
    assign done_o      = done_q;
    assign remaining_o = remaining_q;
    assign rnd_idx_o   = busy ? (MAX_W - remaining_q) : '0;
    assign step_o      = SW'(step_w);

endmodule
